systolic_skew_feeder: RTL

//  Transmit side of the PE-array operand interface. Buffers matrix A (N x K) and

---
 rtl/systolic_skew_feeder_if.sv | 32 +++
 rtl/systolic_skew_feeder.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/systolic_skew_feeder_if.sv
// Operand-feed bus between a controller and the systolic skew feeder.
// Carries buffer writes, the start strobe and the skewed edge streams.
interface systolic_skew_feeder_if #(
    parameter int N  = 4,
    parameter int K  = 4,
    parameter int DW = 32
);
    localparam int IW = $clog2((N > K) ? N : K);

    logic            wr_en;
    logic            wr_sel;
    logic [IW-1:0]   wr_row;
    logic [IW-1:0]   wr_col;
    logic [DW-1:0]   wr_data;
    logic            start;
    logic            busy;
    logic            pe_clr;
    logic [N*DW-1:0] a_out;
    logic [N*DW-1:0] b_out;
    logic            feed_valid;
    logic            done;

    modport master (
        output wr_en, wr_sel, wr_row, wr_col, wr_data, start,
        input  busy, pe_clr, a_out, b_out, feed_valid, done
    );

    modport slave (
        input  wr_en, wr_sel, wr_row, wr_col, wr_data, start,
        output busy, pe_clr, a_out, b_out, feed_valid, done
    );
endinterface

// File: rtl/systolic_skew_feeder.sv
// Buffers A (N x K) and B (K x N) and streams them diagonally skewed into the
// west and north edges of an N x N systolic PE array.

// One edge lane: lane L emits words[step-L] while that index lies in 0..K-1.
module systolic_skew_lane #(
    parameter int K    = 4,
    parameter int DW   = 32,
    parameter int SW   = 3,
    parameter int LANE = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load,
    input  logic [SW-1:0]         step,
    input  logic [K-1:0][DW-1:0]  words,
    output logic [DW-1:0]         q
);
    logic [DW-1:0] sel;

    always_comb begin
        sel = '0;
        for (int k = 0; k < K; k++)
            if (step == SW'(LANE + k)) sel = words[k];
    end

    always_ff @(posedge clk) begin
        if (reset)     q <= '0;
        else if (load) q <= sel;
        else           q <= '0;
    end
endmodule

module systolic_skew_feeder #(
    parameter int N  = 4,
    parameter int K  = 4,
    parameter int DW = 32
) (
    input logic                    clk,
    input logic                    reset,
    systolic_skew_feeder_if.slave  bus
);
    localparam int IW = $clog2((N > K) ? N : K);
    localparam int SW = $clog2(K + N);
    localparam logic [SW-1:0] FEED_LAST  = SW'(K + N - 2);
    localparam logic [SW-1:0] DRAIN_LAST = SW'(N - 1);

    typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_FEED, S_DRAIN, S_DONE} state_t;

    state_t                        state;
    logic [SW-1:0]                 cnt;
    // A stored by row, B stored by column, so each lane sees one packed vector
    logic [N-1:0][K-1:0][DW-1:0]   a_buf;
    logic [N-1:0][K-1:0][DW-1:0]   b_buf;
    logic [N-1:0][DW-1:0]          a_q;
    logic [N-1:0][DW-1:0]          b_q;
    logic                          feed_ld;
    logic [SW-1:0]                 feed_s;
    logic                          wr_ok;

    assign wr_ok = (state == S_IDLE) && bus.wr_en;

    // Buffers deliberately survive reset so a run can be repeated without reloading
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            for (int i = 0; i < N; i++)
                for (int k = 0; k < K; k++) begin
                    if (!bus.wr_sel && bus.wr_row == IW'(i) && bus.wr_col == IW'(k))
                        a_buf[i][k] <= bus.wr_data;
                    if (bus.wr_sel && bus.wr_row == IW'(k) && bus.wr_col == IW'(i))
                        b_buf[i][k] <= bus.wr_data;
                end
        end
    end

    // Lanes register the step the FSM is about to enter, so streams align with FEED
    always_comb begin
        feed_ld = (state == S_CLEAR) || (state == S_FEED && cnt != FEED_LAST);
        feed_s  = (state == S_FEED) ? cnt + 1'b1 : '0;
    end

    for (genvar g = 0; g < N; g++) begin : g_lane
        systolic_skew_lane #(.K(K), .DW(DW), .SW(SW), .LANE(g)) u_a (
            .clk(clk), .reset(reset), .load(feed_ld), .step(feed_s),
            .words(a_buf[g]), .q(a_q[g])
        );
        systolic_skew_lane #(.K(K), .DW(DW), .SW(SW), .LANE(g)) u_b (
            .clk(clk), .reset(reset), .load(feed_ld), .step(feed_s),
            .words(b_buf[g]), .q(b_q[g])
        );
    end

    assign bus.a_out = a_q;
    assign bus.b_out = b_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= S_IDLE;
            cnt            <= '0;
            bus.busy       <= 1'b0;
            bus.pe_clr     <= 1'b0;
            bus.feed_valid <= 1'b0;
            bus.done       <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (bus.start) begin
                    state      <= S_CLEAR;
                    bus.busy   <= 1'b1;
                    bus.pe_clr <= 1'b1;
                end
                S_CLEAR: begin
                    state          <= S_FEED;
                    cnt            <= '0;
                    bus.pe_clr     <= 1'b0;
                    bus.feed_valid <= 1'b1;
                end
                S_FEED: begin
                    if (cnt == FEED_LAST) begin
                        state          <= S_DRAIN;
                        cnt            <= '0;
                        bus.feed_valid <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_DRAIN: begin
                    if (cnt == DRAIN_LAST) begin
                        state    <= S_DONE;
                        bus.busy <= 1'b0;
                        bus.done <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    state    <= S_IDLE;
                    bus.done <= 1'b0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
